// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin search helper for rr_pipe_arbiter.
// rr_pick returns the first set request at or after ptr, wrapping within n.
package rr_arb_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef int unsigned uint_t;

  localparam uint_t MAX_N = 32;
  localparam uint_t IDXW  = $clog2(MAX_N);

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input uint_t            ptr,
                                    input uint_t            n);
    pick_t res;
    uint_t k;
    res = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (!res.hit && req[k]) begin
          res.hit = 1'b1;
          res.idx = k[IDXW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready stage with a registered output and a skid register,
// so in_ready depends only on local state.
module pipe_skid_buffer #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data
);

  logic              skid_valid;
  logic [DWIDTH-1:0] skid_data;

  assign in_ready = !skid_valid;

  // Output register refills from the skid entry first to keep beat order.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/rr_pipe_arbiter.sv
// Round-robin arbiter feeding one skid-buffered stage tagged with source index.
// Define RR_ARB_PKT_LOCK_EN to hold the grant until a beat with i_last is accepted.
module rr_pipe_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int unsigned N      = 4,
  parameter  int unsigned DWIDTH = 8,
  localparam int unsigned SW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N-1:0]        i_valid,
  input  logic [N*DWIDTH-1:0] i_data,
  input  logic [N-1:0]        i_last,
  output logic [N-1:0]        i_ready,
  output logic [DWIDTH-1:0]   o_data,
  output logic [SW-1:0]       o_src,
  output logic                o_valid,
  input  logic                o_ready
);

  state_t                 state, state_n;
  logic [SW-1:0]          gnt, gnt_n, ptr, ptr_n, gnt_inc;
  logic [MAX_N-1:0]       req_all, req_others;
  pick_t                  pick_idle, pick_next;
  logic                   accept, rearb;
  logic                   buf_valid, buf_ready;
  logic [SW+DWIDTH-1:0]   buf_data, buf_out;
  logic                   unused_bits;

  assign gnt_inc  = (uint_t'(gnt) == N - 1) ? '0 : gnt + 1'b1;
  assign buf_data = {gnt, i_data[uint_t'(gnt)*DWIDTH +: DWIDTH]};

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    ptr_n      = ptr;
    i_ready    = '0;
    buf_valid  = 1'b0;
    accept     = 1'b0;
    rearb      = 1'b0;
    req_all    = '0;
    req_all[N-1:0] = i_valid;
    req_others = req_all;
    req_others[gnt] = 1'b0;
    pick_idle  = rr_pick(req_all, uint_t'(ptr), N);
    pick_next  = rr_pick(req_others, uint_t'(gnt_inc), N);
    case (state)
      IDLE: begin
        if (pick_idle.hit) begin
          gnt_n   = pick_idle.idx[SW-1:0];
          state_n = BUSY;
        end
      end
      BUSY: begin
        i_ready[gnt] = buf_ready;
        buf_valid    = i_valid[gnt];
        accept       = i_valid[gnt] && buf_ready;
`ifdef RR_ARB_PKT_LOCK_EN
        rearb        = accept && i_last[gnt];
`else
        rearb        = accept;
`endif
        // Next grant is chosen in the accept cycle so contenders stream without a bubble.
        if (rearb) begin
          ptr_n = gnt_inc;
          if (pick_next.hit) gnt_n = pick_next.idx[SW-1:0];
          else               state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef RR_ARB_PKT_LOCK_EN
  assign unused_bits = ^{pick_idle.idx, pick_next.idx};
`else
  assign unused_bits = ^{pick_idle.idx, pick_next.idx, i_last};
`endif

  pipe_skid_buffer #(.DWIDTH(SW + DWIDTH)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (buf_valid),
    .in_ready  (buf_ready),
    .in_data   (buf_data),
    .out_valid (o_valid),
    .out_ready (o_ready),
    .out_data  (buf_out)
  );

  assign {o_src, o_data} = buf_out;

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Bench for rr_pipe_arbiter: directed vector table, a protocol-violation sequence,
// and randomized traffic against a queue-based reference model with per-source scoreboard.
module tb_rr_pipe_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  i_valid = '0;
  logic [3:0]  i_last = '0;
  logic [31:0] i_data = '0;
  logic [3:0]  i_ready;
  logic [7:0]  o_data;
  logic [1:0]  o_src;
  logic        o_valid;
  logic        o_ready = 1'b0;

  always #5 clk = ~clk;

  rr_pipe_arbiter #(.N(N), .DWIDTH(DW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_src   (o_src),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: grant state plus an in-flight queue of {src, data}.
  bit         m_busy;
  int         m_gnt, m_ptr;
  logic [9:0] q[$];

  logic [3:0] s_rdy;
  logic       s_ov;
  logic [7:0] s_od;
  logic [1:0] s_os;

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic [3:0] l;
    logic [31:0] d;
    bit         ordy;
    logic [3:0] er;
    bit         eov;
    logic [1:0] es;
    logic [7:0] ed;
    bit         ec;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(bit rst, logic [3:0] v, logic [3:0] l, logic [31:0] d, bit ordy,
                              logic [3:0] er, bit eov, logic [1:0] es, logic [7:0] ed, bit ec);
    row_t r;
    r.rst = rst; r.v = v; r.l = l; r.d = d; r.ordy = ordy;
    r.er = er; r.eov = eov; r.es = es; r.ed = ed; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_gnt  = 0;
    m_ptr  = 0;
    q.delete();
  endtask

  task automatic model_check(input bit rst);
    logic [3:0] er;
    if (rst) model_reset();
    er = '0;
    if (m_busy && q.size() < 2) er[m_gnt] = 1'b1;
    chk("m_i_ready", 32'(i_ready), 32'(er));
    chk("m_o_valid", 32'(o_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("m_o_data", 32'(o_data), 32'(q[0][7:0]));
      chk("m_o_src", 32'(o_src), 32'(q[0][9:8]));
    end else if (rst) begin
      chk("m_rst_o_data", 32'(o_data), 32'd0);
      chk("m_rst_o_src", 32'(o_src), 32'd0);
    end
  endtask

  task automatic model_update(input bit rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input bit ordy);
    bit in_rdy, acc, oacc, rearb, found;
    int k, g;
    if (rst) begin
      model_reset();
      return;
    end
    in_rdy = (q.size() < 2);
    acc    = m_busy && v[m_gnt] && in_rdy;
    oacc   = (q.size() > 0) && ordy;
    if (oacc) void'(q.pop_front());
    if (acc) q.push_back({m_gnt[1:0], d[m_gnt*8 +: 8]});
`ifdef RR_ARB_PKT_LOCK_EN
    rearb = acc && l[m_gnt];
`else
    rearb = acc && (l == l);
`endif
    found = 1'b0;
    if (!m_busy) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && v[k]) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_gnt  = k;
        end
      end
    end else if (rearb) begin
      g     = m_gnt;
      m_ptr = (g + 1) % N;
      for (int i = 1; i < N; i++) begin
        k = (g + i) % N;
        if (!found && v[k]) begin
          found = 1'b1;
          m_gnt = k;
        end
      end
      if (!found) m_busy = 1'b0;
    end
  endtask

  task automatic step(input bit rst, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input bit ordy);
    @(negedge clk);
    rstn    = rst;
    i_valid = v;
    i_last  = l;
    i_data  = d;
    o_ready = ordy;
    #1;
    model_check(rst);
    s_rdy = i_ready;
    s_ov  = o_valid;
    s_od  = o_data;
    s_os  = o_src;
    @(posedge clk);
    model_update(rst, v, l, d, ordy);
  endtask

  initial begin
    bit         rv[4];
    bit         rl[4];
    int         seq_s[4];
    int         seq_r[4];
    int         beats;
    logic [3:0] v, l;
    logic [31:0] d;
    bit         ordy;

    model_reset();

    // Test 1: sole requester, one bubble per beat.
    rows.push_back(mk(1, 4'b0000, 4'hF, 32'h0,  1, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b0001, 4'hF, 32'h11, 1, 4'b0000, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0001, 4'hF, 32'h11, 1, 4'b0001, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0001, 4'hF, 32'h12, 1, 4'b0000, 1, 0, 8'h11, 1));
    rows.push_back(mk(0, 4'b0001, 4'hF, 32'h12, 1, 4'b0001, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0001, 4'hF, 32'h13, 1, 4'b0000, 1, 0, 8'h12, 1));
    rows.push_back(mk(0, 4'b0001, 4'hF, 32'h13, 1, 4'b0001, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,  1, 4'b0000, 1, 0, 8'h13, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,  1, 4'b0000, 0, 0, 8'h00, 0));
    // Test 2: all requesting, 0,1,2,3,0 at one beat per cycle.
    rows.push_back(mk(1, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b1111, 4'hF, 32'h23222120, 1, 4'b0000, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b1111, 4'hF, 32'h23222120, 1, 4'b0001, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b1111, 4'hF, 32'h23222120, 1, 4'b0010, 1, 0, 8'h20, 1));
    rows.push_back(mk(0, 4'b1111, 4'hF, 32'h23222120, 1, 4'b0100, 1, 1, 8'h21, 1));
    rows.push_back(mk(0, 4'b1111, 4'hF, 32'h23222120, 1, 4'b1000, 1, 2, 8'h22, 1));
    rows.push_back(mk(0, 4'b1111, 4'hF, 32'h23222120, 1, 4'b0001, 1, 3, 8'h23, 1));
    rows.push_back(mk(0, 4'b1111, 4'hF, 32'h23222120, 1, 4'b0010, 1, 0, 8'h20, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0100, 1, 1, 8'h21, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0100, 0, 0, 8'h00, 0));
    // Test 3: downstream stall holds output, then 1 and 3 drain in order.
    rows.push_back(mk(1, 4'b0000, 4'hF, 32'h0,        0, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b1010, 4'hF, 32'h33003100, 0, 4'b0000, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b1010, 4'hF, 32'h33003100, 0, 4'b0010, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b1000, 4'hF, 32'h33003100, 0, 4'b1000, 1, 1, 8'h31, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        0, 4'b0000, 1, 1, 8'h31, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        0, 4'b0000, 1, 1, 8'h31, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 1, 1, 8'h31, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 1, 3, 8'h33, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 0, 0, 8'h00, 0));
    // Test 4: req2 held while req0 asserts; next grant wraps from 3 to 0.
    rows.push_back(mk(1, 4'b0000, 4'hF, 32'h0,        0, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b0100, 4'hF, 32'h00420000, 0, 4'b0000, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0100, 4'hF, 32'h00420000, 0, 4'b0100, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0100, 4'hF, 32'h00430000, 0, 4'b0000, 1, 2, 8'h42, 1));
    rows.push_back(mk(0, 4'b0100, 4'hF, 32'h00430000, 0, 4'b0100, 1, 2, 8'h42, 1));
    rows.push_back(mk(0, 4'b0100, 4'hF, 32'h00440000, 0, 4'b0000, 1, 2, 8'h42, 1));
    rows.push_back(mk(0, 4'b0101, 4'hF, 32'h00440040, 0, 4'b0000, 1, 2, 8'h42, 1));
    rows.push_back(mk(0, 4'b0101, 4'hF, 32'h00440040, 1, 4'b0000, 1, 2, 8'h42, 1));
    rows.push_back(mk(0, 4'b0101, 4'hF, 32'h00440040, 1, 4'b0100, 1, 2, 8'h43, 1));
    rows.push_back(mk(0, 4'b0001, 4'hF, 32'h00000040, 1, 4'b0001, 1, 2, 8'h44, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 1, 0, 8'h40, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 0, 0, 8'h00, 0));
    // Test 5: reset with two beats buffered; arbitration restarts at ptr 0.
    rows.push_back(mk(1, 4'b0000, 4'hF, 32'h0,        0, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b0011, 4'hF, 32'h00005150, 0, 4'b0000, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0011, 4'hF, 32'h00005150, 0, 4'b0001, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0010, 4'hF, 32'h00005150, 0, 4'b0010, 1, 0, 8'h50, 1));
    rows.push_back(mk(1, 4'b0110, 4'hF, 32'h00626100, 0, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b0110, 4'hF, 32'h00626100, 1, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b0110, 4'hF, 32'h00626100, 1, 4'b0010, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0100, 4'hF, 32'h00626100, 1, 4'b0100, 1, 1, 8'h61, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 1, 2, 8'h62, 1));
    rows.push_back(mk(0, 4'b0000, 4'hF, 32'h0,        1, 4'b0000, 0, 0, 8'h00, 0));
`ifdef RR_ARB_PKT_LOCK_EN
    // Test 6: req0 three-beat packet stays contiguous ahead of req1.
    rows.push_back(mk(1, 4'b0000, 4'h0,    32'h0,        1, 4'b0000, 0, 0, 8'h00, 1));
    rows.push_back(mk(0, 4'b0011, 4'b0000, 32'h00007A70, 1, 4'b0000, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0011, 4'b0000, 32'h00007A70, 1, 4'b0001, 0, 0, 8'h00, 0));
    rows.push_back(mk(0, 4'b0011, 4'b0000, 32'h00007A71, 1, 4'b0001, 1, 0, 8'h70, 1));
    rows.push_back(mk(0, 4'b0011, 4'b0001, 32'h00007A72, 1, 4'b0001, 1, 0, 8'h71, 1));
    rows.push_back(mk(0, 4'b0010, 4'b0010, 32'h00007A00, 1, 4'b0010, 1, 0, 8'h72, 1));
    rows.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 1, 1, 8'h7A, 1));
    rows.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 0, 8'h00, 0));
`endif

    foreach (rows[i]) begin
      step(rows[i].rst, rows[i].v, rows[i].l, rows[i].d, rows[i].ordy);
      chk($sformatf("row%0d_i_ready", i), 32'(s_rdy), 32'(rows[i].er));
      chk($sformatf("row%0d_o_valid", i), 32'(s_ov), 32'(rows[i].eov));
      if (rows[i].ec) begin
        chk($sformatf("row%0d_o_data", i), 32'(s_od), 32'(rows[i].ed));
        chk($sformatf("row%0d_o_src", i), 32'(s_os), 32'(rows[i].es));
      end
    end

    // Granted requester drops valid: grant must not move to another requester.
    step(1, 4'b0000, 4'hF, 32'h0, 1);
    step(0, 4'b0001, 4'hF, 32'h00820080, 1);
    step(0, 4'b0100, 4'hF, 32'h00820080, 1);
    chk("viol_hold_a", 32'(s_rdy), 32'h1);
    step(0, 4'b0100, 4'hF, 32'h00820080, 1);
    chk("viol_hold_b", 32'(s_rdy), 32'h1);
    chk("viol_no_out", 32'(s_ov), 32'h0);
    step(0, 4'b0101, 4'hF, 32'h00820080, 1);
    chk("viol_accept", 32'(s_rdy), 32'h1);
    step(0, 4'b0100, 4'hF, 32'h00820080, 1);
    chk("viol_next_gnt", 32'(s_rdy), 32'h4);
    chk("viol_out0", 32'(s_od), 32'h80);
    step(0, 4'b0000, 4'hF, 32'h0, 1);
    chk("viol_out2", 32'(s_od), 32'h82);
    chk("viol_out2_src", 32'(s_os), 32'h2);

    // Randomized traffic with per-source in-order scoreboard.
    step(1, 4'b0000, 4'h0, 32'h0, 1);
    beats = 0;
    for (int k = 0; k < N; k++) begin
      rv[k] = 1'b0; rl[k] = 1'b0; seq_s[k] = 0; seq_r[k] = 0;
    end
    for (int c = 0; c < 660; c++) begin
      v = '0; l = '0; d = '0;
      for (int k = 0; k < N; k++) begin
        if (c < 640 && !rv[k] && $urandom_range(0, 99) < 40) rv[k] = 1'b1;
        if (c >= 640) rv[k] = 1'b0;
        v[k] = rv[k];
        l[k] = rl[k];
        d[k*8 +: 8] = {k[1:0], seq_s[k][5:0]};
      end
      ordy = (c >= 640) || ($urandom_range(0, 99) < 60);
      step(0, v, l, d, ordy);
      for (int k = 0; k < N; k++) begin
        if (v[k] && s_rdy[k]) begin
          seq_s[k]++;
          rv[k] = ($urandom_range(0, 1) == 1);
          rl[k] = ($urandom_range(0, 2) == 0);
        end
      end
      if (s_ov && ordy) begin
        beats++;
        chk("sb_tag", 32'(s_od[7:6]), 32'(s_os));
        chk("sb_seq", 32'(s_od[5:0]), 32'(seq_r[s_os][5:0]));
        seq_r[s_os]++;
      end
    end
    for (int k = 0; k < N; k++) chk($sformatf("sb_count%0d", k), 32'(seq_r[k]), 32'(seq_s[k]));
    chk("sb_min_beats", 32'(beats >= 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
